flit_ts_queue: RTL and testbench

//  Timestamped flit buffer that sits directly upstream of the flit-queue controller.

---
 rtl/flit_ts_queue.sv | 103 ++++++++++
 tb/tb_flit_ts_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/flit_ts_queue.sv
// Timestamped flit FIFO: holds flits with injection timestamps and presents the
// head to the flit-queue controller once sim_time has reached the head timestamp.
module flit_ts_queue #(
  parameter int TS_WIDTH   = 8,
  parameter int DATA_WIDTH = 36,
  parameter int LOG_DEPTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enq_valid,
  input  logic [TS_WIDTH-1:0]   enq_ts,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  enq_ready,
  input  logic [TS_WIDTH-1:0]   sim_time,
  input  logic                  deq,
  output logic                  head_ready,
  output logic [TS_WIDTH-1:0]   head_ts,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [LOG_DEPTH:0]    count,
  output logic                  err_ovf,
  output logic                  err_unf
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] DEPTH_C = (LOG_DEPTH+1)'(DEPTH);

  // Handshake: a flit is taken on a clock edge where enq_valid && enq_ready;
  // the head is popped on an edge where deq && head_ready. Any other
  // assertion of enq_valid (while full) or deq (while not ready) is an error.
  logic [TS_WIDTH-1:0]   r_mem_ts   [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [LOG_DEPTH-1:0]  r_wr_ptr;
  logic [LOG_DEPTH-1:0]  r_rd_ptr;
  logic [LOG_DEPTH:0]    r_count;
  logic                  r_err_ovf;
  logic                  r_err_unf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_due;
  logic                  w_head_ready;
  logic                  w_enq_acc;
  logic                  w_deq_acc;
  logic [TS_WIDTH-1:0]   w_head_ts;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [TS_WIDTH-1:0]   w_diff;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  always_comb begin
    w_head_ts   = '0;
    w_head_data = '0;
    if (!w_empty) begin
      w_head_ts   = r_mem_ts[r_rd_ptr];
      w_head_data = r_mem_data[r_rd_ptr];
    end
  end

  // Modular difference below half range means sim_time has reached head_ts.
  assign w_diff       = sim_time - w_head_ts;
  assign w_due        = ~w_diff[TS_WIDTH-1];
  assign w_head_ready = !w_empty && w_due;

  assign w_enq_acc = enq_valid && !w_full;
  assign w_deq_acc = deq && w_head_ready;

  always_ff @(posedge clock) begin
    if (w_enq_acc) begin
      r_mem_ts[r_wr_ptr]   <= enq_ts;
      r_mem_data[r_wr_ptr] <= enq_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (w_enq_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq_acc, w_deq_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (enq_valid && w_full)     r_err_ovf <= 1'b1;
      if (deq && !w_head_ready)    r_err_unf <= 1'b1;
    end
  end

  assign enq_ready  = !w_full;
  assign head_ready = w_head_ready;
  assign head_ts    = w_head_ts;
  assign head_data  = w_head_data;
  assign count      = r_count;
  assign err_ovf    = r_err_ovf;
  assign err_unf    = r_err_unf;

endmodule

// File: tb/tb_flit_ts_queue.sv
// Directed bench for flit_ts_queue: a queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_flit_ts_queue;

  localparam int TSW = 8;
  localparam int DW  = 36;
  localparam int LD  = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enq_valid;
  logic [TSW-1:0] enq_ts;
  logic [DW-1:0]  enq_data;
  logic          enq_ready;
  logic [TSW-1:0] sim_time;
  logic          deq;
  logic          head_ready;
  logic [TSW-1:0] head_ts;
  logic [DW-1:0]  head_data;
  logic [LD:0]    count;
  logic          err_ovf;
  logic          err_unf;

  flit_ts_queue #(.TS_WIDTH(TSW), .DATA_WIDTH(DW), .LOG_DEPTH(LD)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ts(enq_ts), .enq_data(enq_data), .enq_ready(enq_ready),
    .sim_time(sim_time), .deq(deq),
    .head_ready(head_ready), .head_ts(head_ts), .head_data(head_data),
    .count(count), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard / model ----------------
  logic [TSW+DW-1:0] exp_q[$];
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;
  logic              check_en = 1'b0;
  int                n_checks = 0;
  int                n_pass = 0;

  function automatic logic is_due(input logic [TSW-1:0] now, input logic [TSW-1:0] ts);
    int d;
    d = (int'(now) - int'(ts) + 256) % 256;
    return d < 128;
  endfunction

  function automatic logic m_head_ready();
    if (exp_q.size() == 0) return 1'b0;
    return is_due(sim_time, exp_q[0][TSW+DW-1:DW]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge reset_n) begin
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  end

  always @(posedge clock) begin
    if (reset_n === 1'b1) begin
      logic hr, full;
      full = (exp_q.size() == 8);
      hr   = m_head_ready();
      if (enq_valid && full) m_ovf = 1'b1;
      if (deq && !hr)        m_unf = 1'b1;
      if (deq && hr)         void'(exp_q.pop_front());
      if (enq_valid && !full) exp_q.push_back({enq_ts, enq_data});
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      logic [TSW-1:0] e_ts;
      logic [DW-1:0]  e_data;
      e_ts   = '0;
      e_data = '0;
      if (exp_q.size() != 0) begin
        e_ts   = exp_q[0][TSW+DW-1:DW];
        e_data = exp_q[0][DW-1:0];
      end
      chk("m_count",      64'(count),      64'(exp_q.size()));
      chk("m_enq_ready",  64'(enq_ready),  64'(exp_q.size() < 8));
      chk("m_head_ready", 64'(head_ready), 64'(m_head_ready()));
      chk("m_head_ts",    64'(head_ts),    64'(e_ts));
      chk("m_head_data",  64'(head_data),  64'(e_data));
      chk("m_err_ovf",    64'(err_ovf),    64'(m_ovf));
      chk("m_err_unf",    64'(err_unf),    64'(m_unf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0;
    deq       = 1'b0;
  endtask

  task automatic push(input logic [TSW-1:0] ts, input logic [DW-1:0] data);
    enq_valid = 1'b1;
    enq_ts    = ts;
    enq_data  = data;
    step();
    idle();
  endtask

  task automatic pop();
    deq = 1'b1;
    step();
    idle();
  endtask

  task automatic test2_sequence(input string tag);
    sim_time = 8'd3;
    push(8'd5, 36'hA);
    chk({tag, "_count1"},   64'(count),      64'd1);
    chk({tag, "_head_ts5"}, 64'(head_ts),    64'd5);
    chk({tag, "_not_due"},  64'(head_ready), 64'd0);
    chk({tag, "_data"},     64'(head_data),  64'hA);
    sim_time = 8'd5;
    #1;
    chk({tag, "_due"},      64'(head_ready), 64'd1);
    pop();
    chk({tag, "_count0"},   64'(count),      64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b1;
    enq_ts    = '0;
    enq_data  = '0;
    sim_time  = '0;
    idle();
    #2 reset_n = 1'b0;
    check_en = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // 1: reset state
    chk("rst_enq_ready",  64'(enq_ready),  64'd1);
    chk("rst_head_ready", 64'(head_ready), 64'd0);
    chk("rst_count",      64'(count),      64'd0);
    chk("rst_head_ts",    64'(head_ts),    64'd0);
    chk("rst_err_ovf",    64'(err_ovf),    64'd0);
    chk("rst_err_unf",    64'(err_unf),    64'd0);

    // 2: single flit, becomes due at sim_time 5
    test2_sequence("t2");

    // 3: fill, overflow, drain in order
    sim_time = 8'd0;
    for (int i = 0; i < 8; i++) push(8'(i), 36'($urandom));
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    chk("full_count",     64'(count),     64'd8);
    push(8'd9, 36'h123);
    chk("ovf_count", 64'(count),   64'd8);
    chk("ovf_flag",  64'(err_ovf), 64'd1);
    sim_time = 8'd7;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_ts", 64'(head_ts), 64'(i));
      pop();
    end
    chk("drain_empty", 64'(count), 64'd0);

    // 4: wrap-aware due comparison
    push(8'hFE, 36'h1);
    sim_time = 8'h02;
    #1;
    chk("wrap_due", 64'(head_ready), 64'd1);
    pop();
    push(8'h02, 36'h2);
    sim_time = 8'hFE;
    #1;
    chk("wrap_not_due", 64'(head_ready), 64'd0);
    sim_time = 8'h02;
    pop();
    push(8'h80, 36'h3);
    sim_time = 8'h00;
    #1;
    chk("half_range_not_due", 64'(head_ready), 64'd0);
    sim_time = 8'h80;
    #1;
    chk("half_range_due", 64'(head_ready), 64'd1);
    pop();
    chk("t4_no_unf", 64'(err_unf), 64'd0);

    // 5: simultaneous enqueue and dequeue
    sim_time = 8'd10;
    for (int i = 0; i < 3; i++) push(8'(i + 1), 36'(i + 100));
    chk("sim_pre3", 64'(count), 64'd3);
    enq_valid = 1'b1; enq_ts = 8'd4; enq_data = 36'h55; deq = 1'b1;
    step(); idle();
    chk("sim_both3", 64'(count), 64'd3);
    chk("sim_no_unf", 64'(err_unf), 64'd0);
    repeat (3) pop();
    chk("sim_empty", 64'(count), 64'd0);
    enq_valid = 1'b1; enq_ts = 8'd5; enq_data = 36'h66; deq = 1'b1;
    step(); idle();
    chk("empty_enqdeq_count", 64'(count),   64'd1);
    chk("empty_enqdeq_unf",   64'(err_unf), 64'd1);
    for (int i = 0; i < 7; i++) push(8'd6, 36'(i));
    chk("refill_full", 64'(count), 64'd8);
    enq_valid = 1'b1; enq_ts = 8'd7; enq_data = 36'h77; deq = 1'b1;
    step(); idle();
    chk("full_enqdeq_count", 64'(count), 64'd7);
    repeat (7) pop();

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) push(8'd1, 36'(i));
    chk("pre_rst_count", 64'(count), 64'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count",      64'(count),      64'd0);
    chk("async_rst_head_ready", 64'(head_ready), 64'd0);
    chk("async_rst_enq_ready",  64'(enq_ready),  64'd1);
    chk("async_rst_err_unf",    64'(err_unf),    64'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    test2_sequence("t6");

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
